// File: rtl/mdu_ctrl_if.sv
// Multiplier-side bus between mdu_ctrl (master) and the pipelined multiplier.
// The controller drives operands/enable; the multiplier returns product/ready.
interface mdu_ctrl_if;
  logic        mul_ena;
  logic        mul_signed;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_res;
  logic        mul_ready;

  modport master (
    output mul_ena, mul_signed, mul_a, mul_b,
    input  mul_res, mul_ready
  );

  modport slave (
    input  mul_ena, mul_signed, mul_a, mul_b,
    output mul_res, mul_ready
  );
endinterface

// File: rtl/mdu_ctrl.sv
// EX-stage multiply controller feeding mul_ip and owning HI/LO.
// Define MDU_ACC_EN to add MADD/MADDU/MSUB/MSUBU accumulation.
module mdu_ctrl #(
  parameter logic [31:0] HI_RST = 32'h0000_0000,
  parameter logic [31:0] LO_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        stall_in,
  input  logic        flush,
  mdu_ctrl_if.master  mul,
  output logic        stall_out,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  logic   is_mul;
  logic   is_sgn;
  logic   start;
  logic   mt_ok;
  logic   first;

`ifdef MDU_ACC_EN
  logic        is_acc;
  logic        is_sub;
  logic        acc_q;
  logic        sub_q;
  logic [63:0] acc_sum;
`endif

  always_comb begin
    is_mul = 1'b0;
    is_sgn = 1'b0;
`ifdef MDU_ACC_EN
    is_acc = 1'b0;
    is_sub = 1'b0;
`endif
    unique case (op)
      4'h1: begin
        is_mul = 1'b1;
        is_sgn = 1'b1;
      end
      4'h2: is_mul = 1'b1;
`ifdef MDU_ACC_EN
      4'h5: begin
        is_mul = 1'b1;
        is_sgn = 1'b1;
        is_acc = 1'b1;
      end
      4'h6: begin
        is_mul = 1'b1;
        is_acc = 1'b1;
      end
      4'h7: begin
        is_mul = 1'b1;
        is_sgn = 1'b1;
        is_acc = 1'b1;
        is_sub = 1'b1;
      end
      4'h8: begin
        is_mul = 1'b1;
        is_acc = 1'b1;
        is_sub = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign start = ex_valid & ~flush & is_mul;
  assign mt_ok = (state == IDLE) & ex_valid
               & ~stall_in & ~flush;
  assign stall_out = ((state == IDLE) & start)
                   | (state == RUN);
  assign busy = (state != IDLE);

`ifdef MDU_ACC_EN
  assign acc_sum = sub_q ? {hi, lo} - mul.mul_res
                         : {hi, lo} + mul.mul_res;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      hi             <= HI_RST;
      lo             <= LO_RST;
      mul.mul_ena    <= 1'b0;
      mul.mul_signed <= 1'b0;
      mul.mul_a      <= 32'h0;
      mul.mul_b      <= 32'h0;
      first          <= 1'b0;
`ifdef MDU_ACC_EN
      acc_q          <= 1'b0;
      sub_q          <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mul.mul_a      <= src_a;
            mul.mul_b      <= src_b;
            mul.mul_signed <= is_sgn;
            mul.mul_ena    <= 1'b1;
            first          <= 1'b1;
            state          <= RUN;
`ifdef MDU_ACC_EN
            acc_q          <= is_acc;
            sub_q          <= is_sub;
`endif
          end else if (mt_ok && op == 4'h3) begin
            hi <= src_a;
          end else if (mt_ok && op == 4'h4) begin
            lo <= src_a;
          end
        end
        RUN: begin
          first <= 1'b0;
          // the first RUN cycle can only carry a stale ready
          if (flush) begin
            mul.mul_ena <= 1'b0;
            state       <= IDLE;
          end else if (mul.mul_ready && !first) begin
`ifdef MDU_ACC_EN
            {hi, lo} <= acc_q ? acc_sum : mul.mul_res;
`else
            {hi, lo} <= mul.mul_res;
`endif
            mul.mul_ena <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (!stall_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboarded bench for mdu_ctrl with a 5-stage multiplier model.
// Stimulus pushes expected HI/LO; a negedge monitor pops on completion.
module tb_mdu_ctrl;
  localparam logic [31:0] HR = 32'h1111_2222;
  localparam logic [31:0] LR = 32'h3333_4444;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [31:0] src_a = 32'h0;
  logic [31:0] src_b = 32'h0;
  logic        stall_in = 1'b0;
  logic        flush = 1'b0;
  logic        spur = 1'b0;
  logic        stall_out, busy;
  logic [31:0] hi, lo;

  mdu_ctrl_if mif();

  mdu_ctrl #(.HI_RST(HR), .LO_RST(LR)) dut (
    .clk(clk),
    .rst(rst),
    .ex_valid(ex_valid),
    .op(op),
    .src_a(src_a),
    .src_b(src_b),
    .stall_in(stall_in),
    .flush(flush),
    .mul(mif),
    .stall_out(stall_out),
    .hi(hi),
    .lo(lo),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // multiplier model: ready in the 6th consecutive enabled cycle
  logic [2:0]         mcnt = 3'd0;
  logic signed [63:0] sa, sb;
  logic [63:0]        prod;

  always @(posedge clk)
    mcnt <= mif.mul_ena ? mcnt + 3'd1 : 3'd0;

  always_comb begin
    sa = mif.mul_signed ? {{32{mif.mul_a[31]}}, mif.mul_a}
                        : {32'h0, mif.mul_a};
    sb = mif.mul_signed ? {{32{mif.mul_b[31]}}, mif.mul_b}
                        : {32'h0, mif.mul_b};
    prod = sa * sb;
  end

  assign mif.mul_res   = prod;
  assign mif.mul_ready = (mif.mul_ena && mcnt == 3'd5) || spur;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        q[$];
  int          vecs = 0;
  int          errs = 0;
  logic [31:0] cur_a = 32'h0;
  logic [31:0] cur_b = 32'h0;
  logic        cur_s = 1'b0;
  int          scnt = 0;
  logic        pstall = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.hi = h;
    e.lo = l;
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    ex_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    cur_a = a;
    cur_b = b;
    cur_s = (o == 4'h1) || (o == 4'h5) || (o == 4'h7);
    tick;
  endtask

  task automatic wait_done;
    int n = 0;
    while (!(busy && !stall_out) && n < 20) begin
      tick;
      n++;
    end
    if (n >= 20) begin
      vecs++;
      errs++;
      $display("FAIL done_timeout: got busy=%b stall=%b want DONE",
               busy, stall_out);
    end
  endtask

  // monitor: operand stability while enabled, stall length and HI/LO on DONE
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mif.mul_ena) begin
        chk("mul_a", {32'h0, mif.mul_a}, {32'h0, cur_a});
        chk("mul_b", {32'h0, mif.mul_b}, {32'h0, cur_b});
        chk("mul_signed", {63'h0, mif.mul_signed}, {63'h0, cur_s});
      end
      if (stall_out) begin
        scnt++;
      end else if (busy && pstall) begin
        chk("stall_len", 64'(scnt), 64'd7);
        if (q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL sb_pop: got completion want none");
        end else begin
          e = q.pop_front();
          chk("hi", {32'h0, hi}, {32'h0, e.hi});
          chk("lo", {32'h0, lo}, {32'h0, e.lo});
        end
        scnt = 0;
      end else begin
        scnt = 0;
      end
      pstall = stall_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) tick;
    chk("rst_hi", {32'h0, hi}, {32'h0, HR});
    chk("rst_lo", {32'h0, lo}, {32'h0, LR});
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_ena", {63'h0, mif.mul_ena}, 64'h0);
    chk("rst_sgn", {63'h0, mif.mul_signed}, 64'h0);
    chk("rst_ab", {mif.mul_a, mif.mul_b}, 64'h0);
    chk("rst_stall", {63'h0, stall_out}, 64'h0);
    rst = 1'b0;
    tick;

    push(32'hFFFF_FFFF, 32'hFFFF_FFEB);
    issue(4'h1, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_done;
    ex_valid = 1'b0;
    tick;

    push(32'hFFFF_FFFE, 32'h0000_0001);
    issue(4'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    spur = 1'b1;
    src_a = 32'h0;
    src_b = 32'h1234;
    tick;
    spur = 1'b0;
    src_a = 32'h5;
    src_b = 32'hA5A5_A5A5;
    wait_done;
    ex_valid = 1'b0;
    tick;

    issue(4'h1, 32'h5, 32'h5);
    tick;
    tick;
    flush = 1'b1;
    ex_valid = 1'b0;
    tick;
    flush = 1'b0;
    chk("flush_ena", {63'h0, mif.mul_ena}, 64'h0);
    chk("flush_busy", {63'h0, busy}, 64'h0);
    chk("flush_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    spur = 1'b1;
    tick;
    spur = 1'b0;
    chk("idle_rdy_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    chk("idle_rdy_busy", {63'h0, busy}, 64'h0);

    push(32'h0, 32'h6);
    issue(4'h1, 32'h2, 32'h3);
    wait_done;
    stall_in = 1'b1;
    tick;
    chk("done_busy", {63'h0, busy}, 64'h1);
    chk("done_ena", {63'h0, mif.mul_ena}, 64'h0);
    chk("done_stall", {63'h0, stall_out}, 64'h0);
    tick;
    chk("done_busy2", {63'h0, busy}, 64'h1);
    chk("done_ena2", {63'h0, mif.mul_ena}, 64'h0);
    stall_in = 1'b0;
    ex_valid = 1'b0;
    tick;
    chk("done_exit", {63'h0, busy}, 64'h0);
    tick;
    chk("no_reissue", {62'h0, busy, mif.mul_ena}, 64'h0);
    chk("done_hilo", {hi, lo}, 64'h0000_0000_0000_0006);

    ex_valid = 1'b1;
    op = 4'h3;
    src_a = 32'hAAAA_AAAA;
    stall_in = 1'b1;
    tick;
    chk("mthi_stalled", {32'h0, hi}, 64'h0);
    stall_in = 1'b0;
    src_a = 32'h1234_5678;
    #1;
    chk("mthi_nostall", {63'h0, stall_out}, 64'h0);
    tick;
    chk("mthi", {32'h0, hi}, 64'h1234_5678);
    op = 4'h4;
    src_a = 32'h9ABC_DEF0;
    tick;
    chk("mtlo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    push(32'h0, 32'h1);
    issue(4'h2, 32'h1, 32'h1);
    wait_done;
    ex_valid = 1'b0;
    tick;

    issue(4'h1, 32'h7, 32'h7);
    tick;
    tick;
    rst = 1'b1;
    ex_valid = 1'b0;
    tick;
    rst = 1'b0;
    chk("midrst_hilo", {hi, lo}, {HR, LR});
    chk("midrst_busy", {62'h0, busy, mif.mul_ena}, 64'h0);
    tick;

    ex_valid = 1'b1;
    op = 4'h3;
    src_a = 32'h0;
    tick;
    op = 4'h4;
    src_a = 32'h5;
    tick;
`ifdef MDU_ACC_EN
    push(32'h0, 32'hB);
    issue(4'h5, 32'h2, 32'h3);
    wait_done;
    ex_valid = 1'b0;
    tick;
    ex_valid = 1'b1;
    op = 4'h3;
    src_a = 32'h0;
    tick;
    op = 4'h4;
    src_a = 32'h5;
    tick;
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'h7, 32'h2, 32'h3);
    wait_done;
    ex_valid = 1'b0;
    tick;
`else
    for (int i = 5; i <= 8; i++) begin
      op = 4'(i);
      src_a = 32'h2;
      src_b = 32'h3;
      #1;
      chk("acc_nostall", {63'h0, stall_out}, 64'h0);
      tick;
      chk("acc_nop_busy", {63'h0, busy}, 64'h0);
      chk("acc_nop_hilo", {hi, lo}, 64'h0000_0000_0000_0005);
    end
    ex_valid = 1'b0;
    tick;
`endif

    repeat (3) tick;
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
